// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute datapath:
//   - 7-bit opcode encodings (OP_NOP .. OP_XOR)
//   - FSM state encoding (ST_IDLE, ST_READ, ST_EXEC, ST_WB)
//   - bit positions of N/Z/C/V inside the 4-bit flags word
//   - helper predicates used by the ALU decode
// ---------------------------------------------------------------------------
package exec_pkg;

    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_LI  = 7'h01;
    localparam logic [6:0] OP_ADD = 7'h02;
    localparam logic [6:0] OP_SUB = 7'h03;
    localparam logic [6:0] OP_AND = 7'h04;
    localparam logic [6:0] OP_OR  = 7'h05;
    localparam logic [6:0] OP_XOR = 7'h06;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // flags = {N, Z, C, V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Arithmetic/logic ops: the only ones that update the condition flags.
    function automatic logic is_alu_op(input logic [6:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/exec_datapath_regfile.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// SIZE x WORDSIZE register file, two combinational read ports, one
// synchronous write port. Register 0 is hardwired to zero: it is never
// written and its read port value is forced to zero.
// Ports:
//   clk, rst        clock / synchronous active-high clear of all entries
//   we, waddr,wdata write port (write happens at the clock edge)
//   raddr1/rdata1   read port 1 (combinational)
//   raddr2/rdata2   read port 2 (combinational)
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32,
    localparam int ADDR_W  = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr1,
    output logic [WORDSIZE-1:0] rdata1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [WORDSIZE-1:0] rdata2
);

    logic [WORDSIZE-1:0] mem [SIZE];
    logic [SIZE-1:0]     wsel;

    // One-hot write decode; entry 0 never gets a write strobe.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_wsel
            if (gi == 0) begin : g_zero
                assign wsel[gi] = 1'b0;
            end else begin : g_entry
                assign wsel[gi] = we && (waddr == ADDR_W'(gi));
            end
        end
    endgenerate

    // The synchronous clear of every entry rules out a RAM macro here;
    // the file is built from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (wsel[i]) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/exec_datapath.sv
// ---------------------------------------------------------------------------
// exec_datapath
// Execute datapath: instruction latch, 4-state sequencer
// (IDLE -> READ -> EXEC -> WB), ALU and a 2-read/1-write register file.
// One instruction is accepted per valid/ready handshake; its result is
// presented for exactly one cycle (the WB cycle) on res_valid.
//
// Build option: define FLAGS_EN to register N/Z/C/V flags for the
// arithmetic/logic ops; otherwise flags is tied to zero.
//
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   op_valid, op_ready    instruction handshake
//   op_code, rs1, rs2, rd instruction fields
//   rd_in                 immediate for LI (sign-extended)
//   rs1_out, rs2_out      operands captured in READ, held until next READ
//   res_valid             one-cycle result strobe (WB cycle)
//   res_data, res_rd      result value and destination index
//   err                   illegal-opcode strobe, coincident with res_valid
//   flags                 {N,Z,C,V}
// ---------------------------------------------------------------------------
module exec_datapath
    import exec_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32,
    parameter int IMM_W    = 32,
    parameter int ADDR_W   = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [6:0]          op_code,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    input  logic [ADDR_W-1:0]   rd,
    input  logic [IMM_W-1:0]    rd_in,
    output logic [WORDSIZE-1:0] rs1_out,
    output logic [WORDSIZE-1:0] rs2_out,
    output logic                res_valid,
    output logic [WORDSIZE-1:0] res_data,
    output logic [ADDR_W-1:0]   res_rd,
    output logic                err,
    output logic [3:0]          flags
);

    state_t              state_reg;
    logic [6:0]          op_reg;
    logic [ADDR_W-1:0]   rs1_reg;
    logic [ADDR_W-1:0]   rs2_reg;
    logic [ADDR_W-1:0]   rd_reg;
    logic [IMM_W-1:0]    imm_reg;
    logic                wen_reg;

    logic [WORDSIZE-1:0] rf_rdata1;
    logic [WORDSIZE-1:0] rf_rdata2;
    logic                rf_we;

    logic [WORDSIZE-1:0] add_res;
    logic [WORDSIZE-1:0] sub_res;
    logic [WORDSIZE-1:0] alu_result;
    logic                alu_write;
    logic                alu_err;

    // res_data/res_rd double as the write-back holding register: they are
    // loaded in EXEC and the register file consumes them at the end of WB.
    assign rf_we = (state_reg == ST_WB) && wen_reg;

    regfile_2r1w #(
        .WORDSIZE (WORDSIZE),
        .SIZE     (SIZE)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (res_rd),
        .wdata  (res_data),
        .raddr1 (rs1_reg),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2_reg),
        .rdata2 (rf_rdata2)
    );

`ifdef FLAGS_EN
    logic [WORDSIZE:0] add_full;
    logic [WORDSIZE:0] sub_full;
    logic [3:0]        flags_reg;
    logic [3:0]        flags_next;

    // Subtraction as a + ~b + 1 so the carry-out is borrow-not (a >= b).
    assign add_full = {1'b0, rs1_out} + {1'b0, rs2_out};
    assign sub_full = {1'b0, rs1_out} + {1'b0, ~rs2_out} + {{WORDSIZE{1'b0}}, 1'b1};
    assign add_res  = add_full[WORDSIZE-1:0];
    assign sub_res  = sub_full[WORDSIZE-1:0];
`else
    assign add_res  = rs1_out + rs2_out;
    assign sub_res  = rs1_out - rs2_out;
`endif

    always_comb begin
        alu_result = '0;
        alu_write  = 1'b0;
        alu_err    = 1'b0;
        case (op_reg)
            OP_NOP: ;
            OP_LI: begin
                alu_result = WORDSIZE'($signed(imm_reg));
                alu_write  = 1'b1;
            end
            OP_ADD: begin
                alu_result = add_res;
                alu_write  = 1'b1;
            end
            OP_SUB: begin
                alu_result = sub_res;
                alu_write  = 1'b1;
            end
            OP_AND: begin
                alu_result = rs1_out & rs2_out;
                alu_write  = 1'b1;
            end
            OP_OR: begin
                alu_result = rs1_out | rs2_out;
                alu_write  = 1'b1;
            end
            OP_XOR: begin
                alu_result = rs1_out ^ rs2_out;
                alu_write  = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

`ifdef FLAGS_EN
    always_comb begin
        flags_next = flags_reg;
        if (is_alu_op(op_reg)) begin
            flags_next[FLAG_N] = alu_result[WORDSIZE-1];
            flags_next[FLAG_Z] = (alu_result == '0);
            flags_next[FLAG_C] = 1'b0;
            flags_next[FLAG_V] = 1'b0;
            if (op_reg == OP_ADD) begin
                flags_next[FLAG_C] = add_full[WORDSIZE];
                // Same-sign operands producing an opposite-sign sum.
                flags_next[FLAG_V] = (rs1_out[WORDSIZE-1] == rs2_out[WORDSIZE-1]) &&
                                     (add_res[WORDSIZE-1] != rs1_out[WORDSIZE-1]);
            end else if (op_reg == OP_SUB) begin
                flags_next[FLAG_C] = sub_full[WORDSIZE];
                // Different-sign operands where the difference flips sign of rs1.
                flags_next[FLAG_V] = (rs1_out[WORDSIZE-1] != rs2_out[WORDSIZE-1]) &&
                                     (sub_res[WORDSIZE-1] != rs1_out[WORDSIZE-1]);
            end
        end
    end

    assign flags = flags_reg;
`else
    assign flags = 4'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_ready  <= 1'b1;
            op_reg    <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rd_reg    <= '0;
            imm_reg   <= '0;
            wen_reg   <= 1'b0;
            rs1_out   <= '0;
            rs2_out   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            err       <= 1'b0;
`ifdef FLAGS_EN
            flags_reg <= 4'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_reg    <= op_code;
                        rs1_reg   <= rs1;
                        rs2_reg   <= rs2;
                        rd_reg    <= rd;
                        imm_reg   <= rd_in;
                        op_ready  <= 1'b0;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    rs1_out   <= rf_rdata1;
                    rs2_out   <= rf_rdata2;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_data  <= alu_result;
                    res_rd    <= rd_reg;
                    wen_reg   <= alu_write;
                    err       <= alu_err;
                    res_valid <= 1'b1;
`ifdef FLAGS_EN
                    flags_reg <= flags_next;
`endif
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    res_valid <= 1'b0;
                    err       <= 1'b0;
                    res_data  <= '0;
                    res_rd    <= '0;
                    wen_reg   <= 1'b0;
                    op_ready  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    op_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
